// File: rtl/maple_pattern_gen.sv
// maple_pattern_gen
//   Maple bus framing-pattern generator. On an accepted request it drives
//   SDCKA/SDCKB through either the start-of-frame pattern (mode=0) or the
//   end-of-frame pattern (mode=1), then pulses done for one cycle.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-low reset
//   start  : request strobe, only honoured in IDLE
//   mode   : pattern select, latched when start is accepted
//   abort  : synchronous cancel back to IDLE, suppresses done
//   busy   : high whenever the generator is not IDLE
//   done   : one-cycle pulse after the pattern completes
//   oe     : high while this block owns the bus lines (LEAD..TRAIL)
//   sdcka  : bus line A, idle high
//   sdckb  : bus line B, idle high
module maple_pattern_gen #(
   parameter int TICKS        = 4,
   parameter int START_PULSES = 4,
   parameter int END_PULSES   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic mode,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic oe,
   output logic sdcka,
   output logic sdckb
);

   // A 1-bit tick counter is still needed when TICKS == 1.
   localparam int TW   = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int MAXP = (START_PULSES > END_PULSES) ? START_PULSES : END_PULSES;
   localparam int PW   = (MAXP > 0) ? $clog2(MAXP + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      PULSE_LO,
      PULSE_HI,
      TRAIL,
      DONE
   } state_t;

   state_t          state, state_nx;
   logic            mode_q, mode_nx;
   logic [TW-1:0]   tick;
   logic [PW-1:0]   npulse, npulse_nx;
   logic            phase_end;
   logic            last_pulse;

   // Line levels for a given state and pattern. The "released" level of
   // the active line is 1 and the other line is held low, except in
   // PULSE_LO where both are low.
   function automatic logic [1:0] lines_for(input state_t s, input logic m);
      case (s)
         LEAD, PULSE_HI, TRAIL: lines_for = m ? 2'b10 : 2'b01;
         PULSE_LO:              lines_for = 2'b00;
         default:               lines_for = 2'b11;
      endcase
   endfunction

   assign phase_end  = (tick == TW'(TICKS - 1));
   // npulse counts completed PULSE_HI phases; the current one is the last
   // when it would bring the count up to the selected pulse total.
   assign last_pulse = ((int'(npulse) + 1) >= (mode_q ? END_PULSES : START_PULSES));

   always_comb begin
      state_nx  = state;
      mode_nx   = mode_q;
      npulse_nx = npulse;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nx  = LEAD;
                  mode_nx   = mode;
                  npulse_nx = '0;
               end
            end
            LEAD:     if (phase_end) state_nx = PULSE_LO;
            PULSE_LO: if (phase_end) state_nx = PULSE_HI;
            PULSE_HI: begin
               if (phase_end) begin
                  if (last_pulse) begin
                     state_nx = TRAIL;
                  end else begin
                     state_nx  = PULSE_LO;
                     npulse_nx = npulse + 1'b1;
                  end
               end
            end
            TRAIL:    if (phase_end) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they switch on the same
   // edge as the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         mode_q <= 1'b0;
         npulse <= '0;
         tick   <= '0;
         sdcka  <= 1'b1;
         sdckb  <= 1'b1;
         oe     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         mode_q <= mode_nx;
         npulse <= npulse_nx;
         if ((state_nx != state) || (state == IDLE)) begin
            tick <= '0;
         end else begin
            tick <= tick + 1'b1;
         end
         {sdcka, sdckb} <= lines_for(state_nx, mode_nx);
         oe   <= (state_nx == LEAD) || (state_nx == PULSE_LO) ||
                 (state_nx == PULSE_HI) || (state_nx == TRAIL);
         busy <= (state_nx != IDLE);
         done <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_maple_pattern_gen.sv
// Testbench for maple_pattern_gen. Two instances: one with TICKS=2,
// START_PULSES=4, END_PULSES=2 and one with TICKS=1, START_PULSES=1,
// END_PULSES=2. Expected waveforms are built from the pattern shape
// (lead phase, N low/high pulse pairs, trail phase, done cycle).
module tb_maple_pattern_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic start_a = 1'b0, mode_a = 1'b0, abort_a = 1'b0;
   logic busy_a, done_a, oe_a, sdcka_a, sdckb_a;
   logic start_b = 1'b0, mode_b = 1'b0, abort_b = 1'b0;
   logic busy_b, done_b, oe_b, sdcka_b, sdckb_b;

   int checks   = 0;
   int failures = 0;
   int sel      = 0;

   always #5 clk = ~clk;

   maple_pattern_gen #(.TICKS(2), .START_PULSES(4), .END_PULSES(2)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .abort(abort_a),
      .busy(busy_a), .done(done_a), .oe(oe_a), .sdcka(sdcka_a), .sdckb(sdckb_a)
   );

   maple_pattern_gen #(.TICKS(1), .START_PULSES(1), .END_PULSES(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .abort(abort_b),
      .busy(busy_b), .done(done_b), .oe(oe_b), .sdcka(sdcka_b), .sdckb(sdckb_b)
   );

   // Observation vector {sdcka, sdckb, oe, busy, done}
   function automatic logic [4:0] observe();
      if (sel == 0) return {sdcka_a, sdckb_a, oe_a, busy_a, done_a};
      else          return {sdcka_b, sdckb_b, oe_b, busy_b, done_b};
   endfunction

   // Expected vector for drive cycle idx (0-based) of a pattern with
   // t cycles per phase and n pulses. Phases: 0 lead, odd <2n+1 low,
   // even pulse-high, 2n+1 trail.
   function automatic logic [4:0] exp_drive(input logic m, input int t, input int n, input int idx);
      int   p;
      logic lo;
      p  = idx / t;
      lo = ((p % 2) == 1) && (p != 2 * n + 1);
      if (m) return {~lo, 1'b0, 3'b110};
      else   return {1'b0, ~lo, 3'b110};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic md, input logic ab);
      if (sel == 0) begin
         start_a = st; mode_a = md; abort_a = ab;
      end else begin
         start_b = st; mode_b = md; abort_b = ab;
      end
   endtask

   task automatic check(input string tag, input int cyc, input logic [4:0] expv);
      logic [4:0] obs;
      obs = observe();
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, sel, cyc, obs, expv);
      end
   endtask

   // Runs one request on the selected instance. abort_cyc / reset_cyc
   // (1-based drive cycle, 0 = none) cut the pattern short; mid_start
   // fires a second request with the other mode in the first low phase.
   task automatic do_pattern(input string tag, input logic m, input int abort_cyc,
                             input int reset_cyc, input bit mid_start);
      int t, n, len;
      t   = (sel == 0) ? 2 : 1;
      n   = m ? 2 : ((sel == 0) ? 4 : 1);
      len = (2 + 2 * n) * t;
      drive(1'b1, m, 1'b0);
      step();
      for (int c = 1; c <= len; c++) begin
         if (c > 1) step();
         drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         check(tag, c, exp_drive(m, t, n, c - 1));
         if (c == abort_cyc) begin
            drive(1'b0, m, 1'b1);
            step();
            drive(1'b0, m, 1'b0);
            check({tag, "_abort"}, c + 1, 5'b11000);
            step();
            check({tag, "_abort_idle"}, c + 2, 5'b11000);
            return;
         end
         if (c == reset_cyc) begin
            #2 reset = 1'b0;
            #1 check({tag, "_rst_async"}, c, 5'b11000);
            step();
            check({tag, "_rst_hold"}, c + 1, 5'b11000);
            reset = 1'b1;
            step();
            check({tag, "_rst_rel"}, c + 2, 5'b11000);
            return;
         end
         if (mid_start && (c - 1 == t)) drive(1'b1, ~m, 1'b0);
      end
      step();
      check({tag, "_done"}, len + 1, 5'b11011);
      step();
      check({tag, "_idle"}, len + 2, 5'b11000);
   endtask

   initial begin
      // Reset values on both instances
      #2 reset = 1'b0;
      #1;
      sel = 0; check("reset", 0, 5'b11000);
      sel = 1; check("reset", 0, 5'b11000);
      step();
      step();
      reset = 1'b1;
      step();
      sel = 0; check("post_reset", 0, 5'b11000);
      sel = 1; check("post_reset", 0, 5'b11000);

      // Full start and end patterns, TICKS=2
      sel = 0;
      do_pattern("start_pat", 1'b0, 0, 0, 1'b0);
      do_pattern("end_pat", 1'b1, 0, 0, 1'b0);

      // Second request while busy is ignored
      do_pattern("busy_start", 1'b0, 0, 0, 1'b1);

      // Abort in the second high pulse (phase 4), then a full pattern
      do_pattern("abort", 1'b0, 4 * 2 + 1, 0, 1'b0);
      do_pattern("after_abort", 1'b0, 0, 0, 1'b0);

      // Abort in IDLE blocks a simultaneous start
      drive(1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0);
      check("idle_abort", 1, 5'b11000);
      step();
      check("idle_abort", 2, 5'b11000);

      // Reset during the third low pulse (phase 5)
      do_pattern("reset_mid", 1'b0, 0, 5 * 2 + 1, 1'b0);
      do_pattern("after_reset", 1'b0, 0, 0, 1'b0);

      // TICKS=1, START_PULSES=1, back-to-back requests
      sel = 1;
      do_pattern("edge_pat", 1'b0, 0, 0, 1'b0);
      do_pattern("edge_b2b", 1'b0, 0, 0, 1'b0);
      do_pattern("edge_end", 1'b1, 0, 0, 1'b0);

      // Randomized requests on both instances with idle gaps
      for (int k = 0; k < 8; k++) begin
         int gap;
         sel = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            step();
            check("rand_gap", g, 5'b11000);
         end
         do_pattern("rand_pat", 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
